// File: rtl/fifo_wrr_sched_if.sv
// rtl/fifo_wrr_sched_if.sv - queue-side and output-stream signals of the WRR read scheduler
interface fifo_wrr_sched_if #(
    parameter int NQ = 4,
    parameter int DW = 16,
    parameter int WW = 4,
    parameter int QW = $clog2(NQ)
);
    logic [NQ-1:0]    q_empty;
    logic [NQ*DW-1:0] q_dout;
    logic [NQ-1:0]    q_rd_en;
    logic [NQ*WW-1:0] q_wgt;
    logic [DW-1:0]    out_data;
    logic [QW-1:0]    out_qid;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  q_empty, q_dout, q_wgt, out_ready,
        output q_rd_en, out_data, out_qid, out_valid
    );

    modport slave (
        output q_empty, q_dout, q_wgt, out_ready,
        input  q_rd_en, out_data, out_qid, out_valid
    );
endinterface

// File: rtl/fifo_wrr_sched.sv
// rtl/fifo_wrr_sched.sv - weighted round-robin reader for NQ FWFT queues onto one registered stream
module fifo_wrr_sched #(
    parameter int NQ = 4,
    parameter int DW = 16,
    parameter int WW = 4,
    parameter int QW = $clog2(NQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sched_en,
    output logic              busy,
    fifo_wrr_sched_if.master  bus
);
    typedef enum logic {IDLE, SERVE} state_t;

    state_t          state, state_n;
    logic [QW-1:0]   rr_ptr, rr_ptr_n;
    logic [QW-1:0]   cur_q, cur_q_n;
    logic [WW-1:0]   credit, credit_n;
    logic [QW-1:0]   grant_q, pop_q, scan_idx;
    logic [WW-1:0]   grant_wgt, grant_weff;
    logic            grant_found, adv, pop;

    assign adv = sched_en & (~bus.out_valid | bus.out_ready);

    // First non-empty queue at or after rr_ptr, wrapping modulo NQ.
    always_comb begin
        grant_found = 1'b0;
        grant_q     = '0;
        scan_idx    = '0;
        for (int k = 0; k < NQ; k++) begin
            scan_idx = rr_ptr + QW'(k);
            if (!grant_found && !bus.q_empty[scan_idx]) begin
                grant_found = 1'b1;
                grant_q     = scan_idx;
            end
        end
    end

    assign grant_wgt  = bus.q_wgt[grant_q*WW +: WW];
    assign grant_weff = (grant_wgt == '0) ? WW'(1) : grant_wgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur_q  <= '0;
            credit <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            cur_q  <= cur_q_n;
            credit <= credit_n;
        end
    end

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        cur_q_n  = cur_q;
        credit_n = credit;
        pop      = 1'b0;
        pop_q    = grant_q;
        case (state)
            IDLE: begin
                if (adv && grant_found) begin
                    pop      = 1'b1;
                    pop_q    = grant_q;
                    credit_n = grant_weff - WW'(1);
                    if (grant_weff == WW'(1)) begin
                        rr_ptr_n = grant_q + QW'(1);
                    end else begin
                        state_n = SERVE;
                        cur_q_n = grant_q;
                    end
                end
            end
            SERVE: begin
                if (adv) begin
                    if (!bus.q_empty[cur_q]) begin
                        pop      = 1'b1;
                        pop_q    = cur_q;
                        credit_n = credit - WW'(1);
                        if (credit == WW'(1)) begin
                            state_n  = IDLE;
                            rr_ptr_n = cur_q + QW'(1);
                        end
                    end else begin
                        // Queue ran dry mid-burst: give up the rest of the turn.
                        state_n  = IDLE;
                        rr_ptr_n = cur_q + QW'(1);
                        credit_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.q_rd_en = '0;
        if (pop && !rst) begin
            bus.q_rd_en[pop_q] = 1'b1;
        end
        busy = (state == SERVE);
    end

    // A word already accepted downstream while frozen is retired, never re-presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_qid   <= '0;
        end else if (adv) begin
            bus.out_valid <= pop;
            if (pop) begin
                bus.out_data <= bus.q_dout[pop_q*DW +: DW];
                bus.out_qid  <= pop_q;
            end
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
